// File: rtl/keyexp_mem.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | keyexp_mem : on-chip AES-128/192/256 key expansion into a 128-bit        |
// |              round-key store with a registered, enable-gated read port.  |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+

module sbox (
   input  logic [7:0] a,
   output logic [7:0] y
);
   localparam logic [0:255][7:0] c_table = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };
   assign y = c_table[a];
endmodule

module keyexp_mem #(
   parameter int NK     = 4,
   parameter int ADDR_W = 4
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              start,
   input  logic [255:0]      key_in,
   input  logic [ADDR_W-1:0] add,
   input  logic              en,
   output logic [127:0]      dout,
   output logic              busy,
   output logic              ready
);
   localparam int NR      = NK + 6;
   localparam int c_words = 4 * (NR + 1);
   localparam int c_idx_w = $clog2(c_words);

   if (!(NK == 4 || NK == 6 || NK == 8)) begin : g_bad_nk
      $error("keyexp_mem: NK must be 4, 6 or 8");
   end
   if ((2 ** ADDR_W) < (NR + 1)) begin : g_bad_addr
      $error("keyexp_mem: ADDR_W too narrow for NR+1 round keys");
   end
   if (NK < 8) begin : g_unused_key
      logic w_unused_key;
      assign w_unused_key = ^key_in[255:32*NK];
   end

   typedef enum logic [0:0] {S_IDLE = 1'b0, S_EXPAND = 1'b1} state_t;

   state_t               r_state;
   logic [31:0]          r_win [0:NK-1];
   logic [c_idx_w-1:0]   r_i;
   logic [2:0]           r_mod;
   logic [7:0]           r_rcon;
   logic [31:0]          r_mem [0:c_words-1];

   logic                 w_key_phase;
   logic [31:0]          w_prev;
   logic [31:0]          w_sub_in;
   logic [31:0]          w_sub;
   logic [31:0]          w_temp;
   logic [31:0]          w_new;
   logic [c_idx_w-1:0]   w_base;
   logic [127:0]         w_rd_row;

   // r_win always holds the last NK words, oldest in slot 0; during the key
   // phase it simply rotates, so slot 0 presents key word i.
   assign w_key_phase = (r_i < c_idx_w'(NK));
   assign w_prev      = r_win[NK-1];
   assign w_sub_in    = (r_mod == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

   for (genvar b = 0; b < 4; b++) begin : g_sbox
      sbox u_sbox (.a(w_sub_in[8*b +: 8]), .y(w_sub[8*b +: 8]));
   end

   always_comb begin
      w_temp = w_prev;
      if (r_mod == 3'd0)
         w_temp = w_sub ^ {r_rcon, 24'h0};
      else if (NK == 8 && r_mod == 3'd4)
         w_temp = w_sub;
      w_new = w_key_phase ? r_win[0] : (r_win[0] ^ w_temp);
   end

   always_comb begin
      w_base   = c_idx_w'({add, 2'b00});
      w_rd_row = {r_mem[w_base], r_mem[w_base + c_idx_w'(1)],
                  r_mem[w_base + c_idx_w'(2)], r_mem[w_base + c_idx_w'(3)]};
   end

   // Store is deliberately not reset.
   always_ff @(posedge clock) begin
      if (r_state == S_EXPAND)
         r_mem[r_i] <= w_new;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_i     <= '0;
         r_mod   <= '0;
         r_rcon  <= 8'h01;
         busy    <= 1'b0;
         ready   <= 1'b0;
         dout    <= '0;
         for (int j = 0; j < NK; j++) r_win[j] <= '0;
      end else begin
         if (en)
            dout <= (add > ADDR_W'(NR)) ? 128'h0 : w_rd_row;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  for (int j = 0; j < NK; j++) r_win[j] <= key_in[32*(NK-j)-1 -: 32];
                  r_i     <= '0;
                  r_mod   <= '0;
                  r_rcon  <= 8'h01;
                  busy    <= 1'b1;
                  ready   <= 1'b0;
                  r_state <= S_EXPAND;
               end
            end
            S_EXPAND: begin
               for (int j = 0; j < NK - 1; j++) r_win[j] <= r_win[j+1];
               r_win[NK-1] <= w_new;
               r_i   <= r_i + c_idx_w'(1);
               r_mod <= (r_mod == 3'(NK - 1)) ? 3'd0 : r_mod + 3'd1;
               if (!w_key_phase && r_mod == 3'd0)
                  r_rcon <= {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);
               if (r_i == c_idx_w'(c_words - 1)) begin
                  busy    <= 1'b0;
                  ready   <= 1'b1;
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

`default_nettype wire

// File: tb/tb_keyexp_mem.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_keyexp_mem : self-checking bench for keyexp_mem (NK = 4, 6, 8).       |
// | Revision      : 1.0                                                      |
// +--------------------------------------------------------------------------+
module tb_keyexp_mem;
   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          en = 1'b0;
   logic [3:0]    add = '0;
   logic [255:0]  key4 = '0, key6 = '0, key8 = '0;
   logic [127:0]  dout4, dout6, dout8;
   logic          busy4, busy6, busy8, ready4, ready6, ready8;

   int            n_checks = 0;
   int            n_errors = 0;
   logic [7:0]    sb [0:255];

   always #5 clk = ~clk;

   keyexp_mem #(.NK(4), .ADDR_W(4)) dut4 (.clock(clk), .reset_n(rst_n), .start(start),
      .key_in(key4), .add(add), .en(en), .dout(dout4), .busy(busy4), .ready(ready4));
   keyexp_mem #(.NK(6), .ADDR_W(4)) dut6 (.clock(clk), .reset_n(rst_n), .start(start),
      .key_in(key6), .add(add), .en(en), .dout(dout6), .busy(busy6), .ready(ready6));
   keyexp_mem #(.NK(8), .ADDR_W(4)) dut8 (.clock(clk), .reset_n(rst_n), .start(start),
      .key_in(key8), .add(add), .en(en), .dout(dout8), .busy(busy8), .ready(ready8));

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int k = 0; k < 8; k++) begin
         if (b[0]) p = p ^ a;
         a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(logic [7:0] v, int n);
      logic [15:0] d = {v, v};
      return d[15-n -: 8];
   endfunction

   // S-box from its definition: GF(2^8) inverse followed by the affine map.
   task automatic build_sbox();
      for (int x = 0; x < 256; x++) begin
         logic [7:0] inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] subw(logic [31:0] v);
      return {sb[v[31:24]], sb[v[23:16]], sb[v[15:8]], sb[v[7:0]]};
   endfunction

   function automatic logic [127:0] model_row(logic [255:0] key, int nk, int r);
      logic [31:0] w [0:59];
      logic [31:0] t;
      logic [7:0]  rc = 8'h01;
      int          nr = nk + 6;
      if (r > nr) return 128'h0;
      for (int i = 0; i < 4 * (nr + 1); i++) begin
         if (i < nk) w[i] = key[32*(nk-i)-1 -: 32];
         else begin
            t = w[i-1];
            if (i % nk == 0) begin
               t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
               rc = gmul(rc, 8'h02);
            end else if (nk == 8 && i % nk == 4) t = subw(t);
            w[i] = w[i-nk] ^ t;
         end
      end
      return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endfunction

   function automatic logic [255:0] rand256();
      logic [255:0] v = '0;
      for (int k = 0; k < 8; k++) v = {v[223:0], 32'($urandom)};
      return v;
   endfunction

   task automatic rd(input int a);
      @(negedge clk);
      add = 4'(a);
      en  = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic sweep_all(input string tag);
      for (int a = 0; a < 16; a++) begin
         rd(a);
         check($sformatf("%s_nk4_row%0d", tag, a), dout4, model_row(key4, 4, a));
         check($sformatf("%s_nk6_row%0d", tag, a), dout6, model_row(key6, 6, a));
         check($sformatf("%s_nk8_row%0d", tag, a), dout8, model_row(key8, 8, a));
      end
      @(negedge clk) en = 1'b0;
   endtask

   // Starts all three DUTs together; optional second start pulse (with a different
   // NK=4 key) at clock extra_at, which must be ignored.
   task automatic run_expand(input int extra_at, input logic [255:0] extra4);
      int t4 = 0, t6 = 0, t8 = 0;
      logic [255:0] saved = key4;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      for (int c = 1; c <= 80; c++) begin
         @(posedge clk);
         #1;
         if (c == 1) begin
            check("busy_after_start", {127'h0, busy4}, 128'h1);
            check("ready_drop_on_start", {127'h0, ready4}, 128'h0);
         end
         if (ready4 && t4 == 0) t4 = c;
         if (ready6 && t6 == 0) t6 = c;
         if (ready8 && t8 == 0) t8 = c;
         if (extra_at > 0 && c == extra_at) begin key4 = extra4; start = 1'b1; end
         if (extra_at > 0 && c == extra_at + 1) begin key4 = saved; start = 1'b0; end
      end
      check("latency_nk4", 128'(t4), 128'd44);
      check("latency_nk6", 128'(t6), 128'd52);
      check("latency_nk8", 128'(t8), 128'd60);
      check("busy_done_nk4", {127'h0, busy4}, 128'h0);
   endtask

   initial begin
      build_sbox();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("reset_dout", dout4, 128'h0);
      check("reset_busy", {127'h0, busy4}, 128'h0);
      check("reset_ready", {127'h0, ready4}, 128'h0);

      // Known-answer keys; upper key_in bits carry junk that must be ignored.
      key4 = {128'hfeedfacecafebabe0123456789abcdef, 128'h2b7e151628aed2a6abf7158809cf4f3c};
      key6 = {64'hdeadbeef5a5a5a5a, 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b};
      key8 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
      run_expand(0, '0);
      rd(1);  check("kat_nk4_row1", dout4, 128'ha0fafe1788542cb123a339392a6c7605);
      rd(10); check("kat_nk4_row10", dout4, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      rd(12); check("kat_nk6_row12", dout6, 128'he98ba06f448c773c8ecc720401002202);
      rd(14); check("kat_nk8_row14", dout8, 128'hfe4890d1e6188d0b046df344706c631e);
      rd(0);  check("kat_nk8_row0", dout8, 128'h603deb1015ca71be2b73aef0857d7781);
      rd(15); check("kat_nk4_row15_zero", dout4, 128'h0);
      sweep_all("sweep");

      // en low: output holds while add moves.
      rd(2);
      @(negedge clk) begin en = 1'b0; add = 4'd5; end
      @(posedge clk); #1;
      check("hold_nk4", dout4, model_row(key4, 4, 2));
      @(posedge clk); #1;
      check("hold_nk8", dout8, model_row(key8, 8, 2));

      // Start pulse during expansion is ignored.
      run_expand(20, rand256());
      rd(1);  check("ignore_start_row1", dout4, 128'ha0fafe1788542cb123a339392a6c7605);
      rd(10); check("ignore_start_row10", dout4, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      @(negedge clk) en = 1'b0;

      // Reset mid-expansion.
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      repeat (29) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("midreset_busy", {127'h0, busy4}, 128'h0);
      check("midreset_ready", {127'h0, ready4}, 128'h0);
      check("midreset_dout", dout4, 128'h0);
      @(negedge clk) rst_n = 1'b1;
      repeat (70) @(posedge clk);
      #1;
      check("no_restart_without_start", {127'h0, ready4}, 128'h0);
      run_expand(0, '0);
      rd(10); check("after_reset_row10", dout4, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      @(negedge clk) en = 1'b0;

      // Randomized keys against the reference model.
      for (int n = 0; n < 3; n++) begin
         key4 = rand256();
         key6 = rand256();
         key8 = rand256();
         run_expand(0, '0);
         sweep_all($sformatf("rand%0d", n));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
`default_nettype wire
